fpdiv_sched: RTL
================

Name: fpdiv_sched

Overview:
- Round-robin scheduler that shares one 32-bit floating-point non-restoring divider (fpdiv) among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and sequences the divider.
- Returns the quotient, divider exception code and requester ID over one valid/ready response channel.
- Sits between the requesting units and the single fpdiv instance; exactly one division is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of rsp_id; must satisfy 2^IDW >= NREQ.
- TIMEOUT, 255, maximum WAIT cycles before abort (8-bit counter).

Ports:
- CLOCK  in  1  clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  32*NREQ  dividend, requester i at bits [32i+31:32i].
- req_b  in  32*NREQ  divisor, same packing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester served.
- rsp_result  out  32  quotient (IEEE-754 single).
- rsp_exc  out  2  divider EXCEPTION captured with the result.
- rsp_timeout  out  1  1 = divider never raised DONE; result forced to 0.
- div_a  out  32  to fpdiv InputA.
- div_b  out  32  to fpdiv InputB.
- div_result  in  32  from fpdiv AbyB.
- div_done  in  1  from fpdiv DONE.
- div_exc  in  2  from fpdiv EXCEPTION.

Behaviour:
- FSM states: IDLE, PRIME, LOAD, WAIT, RESP.
- Reset values:
  - state = IDLE; rr_ptr = 0; req_ready = 0.
  - rsp_valid = 0; rsp_id = 0; rsp_result = 0; rsp_exc = 0; rsp_timeout = 0.
  - div_a = 0; div_b = 0; timeout counter = 0.
- RESET mid-operation aborts the in-flight division; no response is produced for it.
- IDLE:
  - Arbitration is round-robin. Search starts at rr_ptr; the first i with req_valid[i]=1 wins.
  - req_ready[winner] = 1 combinationally in IDLE only. The handshake completes in the same cycle.
  - On that edge: latch a, b and id internally; rr_ptr <= winner+1, wrapping NREQ-1 -> 0; go to PRIME.
  - With no valid request: stay in IDLE; rr_ptr unchanged.
- PRIME (1 cycle):
  - div_a = 0, div_b = 0. This hits the divider's divide-by-zero fast path.
  - Guarantees an operand change, so the divider restarts even on back-to-back identical operands.
  - Next state: LOAD.
- LOAD (1 cycle):
  - div_a/div_b = latched operands. div_done is ignored this cycle because it may still reflect PRIME.
  - Clear the timeout counter. Next state: WAIT.
- WAIT:
  - div_a/div_b are held at the latched operands.
  - Each cycle, if div_done = 1: capture div_result and div_exc into rsp_result/rsp_exc; rsp_timeout <= 0; go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: rsp_result <= 0, rsp_exc <= 2'b11, rsp_timeout <= 1; go to RESP.
  - Fast-path cases (B = 0, NaN operands, A = 0) complete with done seen on the first WAIT cycle.
- RESP:
  - rsp_valid = 1 and rsp_id = latched id. All rsp_* fields are stable until accepted.
  - On rsp_valid & rsp_ready: go to IDLE. No new request is accepted in the same cycle.
  - div_a/div_b are held, keeping the divider idle.
- Throughput: at most one request per (4 + divider latency) cycles. Minimum request-to-rsp_valid latency is 4 cycles.
- Requests arriving outside IDLE see req_ready = 0. Requesters must hold req_valid and operands stable until accepted.
- rsp_exc is passed through from the divider unchanged, except on timeout.

Test Plan:
- Single request: req0 a=0x40C00000, b=0x40000000 (6.0/2.0) -> rsp_valid with rsp_result=0x40400000, rsp_id=0, rsp_timeout=0; req_ready[0] high for exactly 1 cycle.
- Divide by zero: req2 a=0x3F800000, b=0x00000000 -> rsp_result=0x7FFFFFFF, rsp_exc=00, rsp_id=2, rsp_valid 4 cycles after accept.
- Round robin: all four requesters held valid with distinct operands -> grants in order 0,1,2,3,0. The rr_ptr wrap is checked, and every rsp_id matches its quotient.
- Identical back-to-back: req1 issues 0x41200000/0x40A00000 twice (10/5) -> both responses are 0x40000000. PRIME is seen forcing div_b=0 before each LOAD.
- Backpressure and timeout: rsp_ready=0 for 20 cycles -> rsp fields stable and req_ready=0 throughout. Then a divider model with done stuck at 0 -> after TIMEOUT WAIT cycles: rsp_timeout=1, rsp_result=0, rsp_exc=11.
- Reset mid-WAIT: RESET asserted for 1 cycle -> next cycle all outputs at reset values, state IDLE, and no stale response appears afterwards.

Source files
------------

// File: rtl/fpdiv_sched.sv
// fpdiv_sched: round-robin front end sharing one fpdiv among NREQ requesters.
// One division in flight; each one goes PRIME (operands 0/0) -> LOAD -> WAIT -> RESP.
module fpdiv_sched #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_result,
  output logic [1:0]           rsp_exc,
  output logic                 rsp_timeout,
  output logic [31:0]          div_a,
  output logic [31:0]          div_b,
  input  logic [31:0]          div_result,
  input  logic                 div_done,
  input  logic [1:0]           div_exc
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  logic [2:0]     r_state;
  logic [PW-1:0]  r_rr_ptr;
  logic [31:0]    r_a;
  logic [31:0]    r_b;
  logic [PW-1:0]  r_id;
  logic [CW-1:0]  r_cnt;
  logic [31:0]    r_div_a;
  logic [31:0]    r_div_b;
  logic           r_rsp_valid;
  logic [IDW-1:0] r_rsp_id;
  logic [31:0]    r_rsp_result;
  logic [1:0]     r_rsp_exc;
  logic           r_rsp_timeout;

  logic [2:0]     w_state_nxt;
  logic [PW-1:0]  w_rr_nxt;
  logic [31:0]    w_a_nxt;
  logic [31:0]    w_b_nxt;
  logic [PW-1:0]  w_id_nxt;
  logic [CW-1:0]  w_cnt_nxt;
  logic [CW-1:0]  w_cnt_inc;
  logic [31:0]    w_div_a_nxt;
  logic [31:0]    w_div_b_nxt;
  logic           w_rv_nxt;
  logic [IDW-1:0] w_rid_nxt;
  logic [31:0]    w_rres_nxt;
  logic [1:0]     w_rexc_nxt;
  logic           w_rto_nxt;

  logic [31:0]    w_opa [NREQ];
  logic [31:0]    w_opb [NREQ];
  logic           w_found;
  logic [PW-1:0]  w_win;
  int unsigned    w_idx;

  // Unpack the flat operand buses into per-requester words
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_opa[i] = req_a[32*i +: 32];
      w_opb[i] = req_b[32*i +: 32];
    end
  end

  // Round-robin search: first valid requester at or after r_rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = (32'(r_rr_ptr) + k) % NREQ;
      if (!w_found && req_valid[PW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = PW'(w_idx);
      end
    end
  end

  // Grant is combinational and only offered while idle and out of reset
  always_comb begin
    req_ready = '0;
    if ((r_state == S_IDLE) && w_found && !RESET) begin
      req_ready[w_win] = 1'b1;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr_ptr;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_id_nxt    = r_id;
    w_cnt_nxt   = r_cnt;
    w_div_a_nxt = r_div_a;
    w_div_b_nxt = r_div_b;
    w_rv_nxt    = r_rsp_valid;
    w_rid_nxt   = r_rsp_id;
    w_rres_nxt  = r_rsp_result;
    w_rexc_nxt  = r_rsp_exc;
    w_rto_nxt   = r_rsp_timeout;
    w_cnt_inc   = r_cnt + CW'(1);
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_a_nxt     = w_opa[w_win];
          w_b_nxt     = w_opb[w_win];
          w_id_nxt    = w_win;
          w_rr_nxt    = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);
          // 0/0 forces an operand change so the divider always restarts
          w_div_a_nxt = 32'd0;
          w_div_b_nxt = 32'd0;
          w_state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        w_div_a_nxt = r_a;
        w_div_b_nxt = r_b;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // div_done may still reflect the 0/0 prime here, so it is ignored
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          w_rres_nxt  = div_result;
          w_rexc_nxt  = div_exc;
          w_rto_nxt   = 1'b0;
          w_rv_nxt    = 1'b1;
          w_rid_nxt   = IDW'(r_id);
          w_state_nxt = S_RESP;
        end else if (w_cnt_inc == CW'(TIMEOUT)) begin
          w_rres_nxt  = 32'd0;
          w_rexc_nxt  = 2'b11;
          w_rto_nxt   = 1'b1;
          w_rv_nxt    = 1'b1;
          w_rid_nxt   = IDW'(r_id);
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_rv_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers, synchronous active-high reset
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_a           <= 32'd0;
      r_b           <= 32'd0;
      r_id          <= '0;
      r_cnt         <= '0;
      r_div_a       <= 32'd0;
      r_div_b       <= 32'd0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_result  <= 32'd0;
      r_rsp_exc     <= 2'b00;
      r_rsp_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_a           <= w_a_nxt;
      r_b           <= w_b_nxt;
      r_id          <= w_id_nxt;
      r_cnt         <= w_cnt_nxt;
      r_div_a       <= w_div_a_nxt;
      r_div_b       <= w_div_b_nxt;
      r_rsp_valid   <= w_rv_nxt;
      r_rsp_id      <= w_rid_nxt;
      r_rsp_result  <= w_rres_nxt;
      r_rsp_exc     <= w_rexc_nxt;
      r_rsp_timeout <= w_rto_nxt;
    end
  end

  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_rsp_id;
  assign rsp_result  = r_rsp_result;
  assign rsp_exc     = r_rsp_exc;
  assign rsp_timeout = r_rsp_timeout;
  assign div_a       = r_div_a;
  assign div_b       = r_div_b;

endmodule
